// File: rtl/aoc25_6_pkg.sv
// Shared types, sizes and the reduction helper for the day-6 column problem sequencer.
package aoc25_6_pkg;

    localparam int ARG_ROWS       = 3;
    localparam int ARG_ROW_WIDTH  = 2;
    localparam int ARG_COL_WIDTH  = 10;
    localparam int ARG_DATA_WIDTH = 16;
    localparam int RESULT_WIDTH   = 64;
    localparam int OP_FIFO_DEPTH  = 8;
    localparam int OP_FIFO_AW     = $clog2(OP_FIFO_DEPTH);
    localparam int ARG_COLS       = 2 ** ARG_COL_WIDTH;

    typedef logic [ARG_ROW_WIDTH-1:0]  arg_row_t;
    typedef logic [ARG_COL_WIDTH-1:0]  arg_col_t;
    typedef logic [ARG_DATA_WIDTH-1:0] arg_data_t;
    typedef logic [RESULT_WIDTH-1:0]   result_t;

    localparam arg_row_t OPERAND_ROW  = arg_row_t'(ARG_ROWS);
    localparam arg_row_t LAST_ARG_ROW = arg_row_t'(ARG_ROWS - 1);

    typedef struct packed {
        arg_col_t col;
        logic     mult_add;
    } op_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REDUCE = 2'd2,
        EMIT   = 2'd3
    } seq_state_t;

    // One step of the column fold; wraps modulo 2**RESULT_WIDTH.
    function automatic result_t reduce_step(input result_t acc, input arg_data_t rd, input logic mult);
        result_t operand;
        operand = result_t'(rd);
        if (mult) begin
            return acc * operand;
        end else begin
            return acc + operand;
        end
    endfunction

endpackage

// File: rtl/column_problem_sequencer_if.sv
// Parser-facing bus of the column problem sequencer: argument/operator strobes in, totals and status out.
interface column_problem_sequencer_if;
    import aoc25_6_pkg::*;

    logic      arg_valid;
    arg_row_t  arg_row;
    arg_col_t  arg_col;
    arg_data_t arg_data;
    logic      operand_valid;
    logic      operand_mult_add;
    logic      end_of_input;
    logic      total_valid;
    result_t   total_data;
    logic      col_result_valid;
    result_t   col_result_data;
    logic      busy;
    logic      error;

    modport master (
        output arg_valid, arg_row, arg_col, arg_data,
        output operand_valid, operand_mult_add, end_of_input,
        input  total_valid, total_data, col_result_valid, col_result_data, busy, error
    );

    modport slave (
        input  arg_valid, arg_row, arg_col, arg_data,
        input  operand_valid, operand_mult_add, end_of_input,
        output total_valid, total_data, col_result_valid, col_result_data, busy, error
    );

endinterface

// File: rtl/op_fifo.sv
// Synchronous first-word-fall-through queue of pending column operators with a sticky overflow flag.
module op_fifo
    import aoc25_6_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  op_entry_t push_data,
    input  logic      pop,
    output op_entry_t pop_data,
    output logic      empty,
    output logic      empty_next,
    output logic      overflow
);

    localparam int            CW        = OP_FIFO_AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(OP_FIFO_DEPTH);

    op_entry_t             entries_q [OP_FIFO_DEPTH];
    logic [OP_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OP_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  do_push_s, do_pop_s;

    // A full queue still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop_s   = pop & ~empty_q;
        do_push_s  = push & (~full_q | do_pop_s);
        wr_ptr_d   = wr_ptr_q + OP_FIFO_AW'(do_push_s);
        rd_ptr_d   = rd_ptr_q + OP_FIFO_AW'(do_pop_s);
        count_d    = count_q + CW'(do_push_s) - CW'(do_pop_s);
        full_d     = (count_d == DEPTH_CNT);
        empty_d    = (count_d == {CW{1'b0}});
        overflow_d = overflow_q | (push & ~do_push_s);
    end

    // Entry storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            entries_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {OP_FIFO_AW{1'b0}};
            rd_ptr_q   <= {OP_FIFO_AW{1'b0}};
            count_q    <= {CW{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    assign pop_data   = entries_q[rd_ptr_q];
    assign empty      = empty_q;
    assign empty_next = empty_d;
    assign overflow   = overflow_q;

endmodule

// File: rtl/column_problem_sequencer.sv
// Stores worksheet arguments per column and folds each column (add or multiply) into a grand total.
// Optional per-column result output is built when COL_RESULT_OUT_EN is defined.
module column_problem_sequencer
    import aoc25_6_pkg::*;
(
    input logic                        clk,
    input logic                        rst,
    column_problem_sequencer_if.slave  bus
);

    seq_state_t state_q, state_d;
    arg_col_t   cur_col_q, cur_col_d;
    arg_col_t   op_col_q, op_col_d;
    arg_row_t   row_q, row_d;
    logic       mult_q, mult_d;
    result_t    acc_q, acc_d;
    result_t    total_q, total_d;
    result_t    total_data_q, total_data_d;
    logic       total_valid_q, total_valid_d;
    logic       eoi_flag_q, eoi_flag_d;
    logic       busy_q, busy_d;
    logic       error_q, error_d;

    arg_data_t  arg_mem_q [ARG_ROWS][ARG_COLS];
    arg_data_t  rd_data_q;
    logic       rd_en_s;
    arg_row_t   rd_row_s;
    arg_col_t   rd_col_s;

    logic       fifo_pop_s, fifo_empty_s, fifo_empty_next_s, fifo_ovf_s;
    op_entry_t  push_entry_s, head_s;
    logic       col_wrap_s, drained_s, done_s;

    op_fifo u_op_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.operand_valid),
        .push_data  (push_entry_s),
        .pop        (fifo_pop_s),
        .pop_data   (head_s),
        .empty      (fifo_empty_s),
        .empty_next (fifo_empty_next_s),
        .overflow   (fifo_ovf_s)
    );

    // Argument storage; the operator row index and above never land in memory.
    always_ff @(posedge clk) begin
        if (bus.arg_valid && (bus.arg_row < OPERAND_ROW)) begin
            arg_mem_q[bus.arg_row][bus.arg_col] <= bus.arg_data;
        end
    end

    // Single registered read port shared by all reduction steps.
    always_ff @(posedge clk) begin
        if (rd_en_s) begin
            rd_data_q <= arg_mem_q[rd_row_s][rd_col_s];
        end
    end

    // Reduction sequencer: one column at a time, one row per cycle behind the read latency.
    always_comb begin
        state_d    = state_q;
        cur_col_d  = cur_col_q;
        mult_d     = mult_q;
        row_d      = row_q;
        acc_d      = acc_q;
        total_d    = total_q;
        fifo_pop_s = 1'b0;
        rd_en_s    = 1'b0;
        rd_row_s   = {ARG_ROW_WIDTH{1'b0}};
        rd_col_s   = cur_col_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    cur_col_d  = head_s.col;
                    mult_d     = head_s.mult_add;
                    rd_en_s    = 1'b1;
                    rd_col_s   = head_s.col;
                    state_d    = FIRST;
                end else begin
                    state_d    = IDLE;
                end
            end
            FIRST: begin
                acc_d    = result_t'(rd_data_q);
                rd_en_s  = 1'b1;
                rd_row_s = arg_row_t'(1);
                row_d    = arg_row_t'(1);
                state_d  = REDUCE;
            end
            REDUCE: begin
                acc_d = reduce_step(acc_q, rd_data_q, mult_q);
                if (row_q == LAST_ARG_ROW) begin
                    state_d = EMIT;
                end else begin
                    row_d    = row_q + arg_row_t'(1);
                    rd_en_s  = 1'b1;
                    rd_row_s = row_q + arg_row_t'(1);
                end
            end
            EMIT: begin
                total_d = total_q + acc_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operator capture, end-of-input completion and sticky status.
    always_comb begin
        push_entry_s.col      = op_col_q;
        push_entry_s.mult_add = bus.operand_mult_add;
        if (bus.operand_valid) begin
            op_col_d = op_col_q + arg_col_t'(1);
        end else begin
            op_col_d = op_col_q;
        end
        col_wrap_s    = bus.operand_valid & (op_col_q == {ARG_COL_WIDTH{1'b1}});
        error_d       = error_q | col_wrap_s | fifo_ovf_s;
        drained_s     = (state_q == IDLE) & fifo_empty_s & ~bus.operand_valid;
        done_s        = (eoi_flag_q | bus.end_of_input) & drained_s;
        eoi_flag_d    = (eoi_flag_q | bus.end_of_input) & ~done_s;
        total_valid_d = done_s;
        if (done_s) begin
            total_data_d = total_q;
        end else begin
            total_data_d = total_data_q;
        end
        busy_d = (state_d != IDLE) | ~fifo_empty_next_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_col_q     <= {ARG_COL_WIDTH{1'b0}};
            op_col_q      <= {ARG_COL_WIDTH{1'b0}};
            row_q         <= {ARG_ROW_WIDTH{1'b0}};
            mult_q        <= 1'b0;
            acc_q         <= {RESULT_WIDTH{1'b0}};
            total_q       <= {RESULT_WIDTH{1'b0}};
            total_data_q  <= {RESULT_WIDTH{1'b0}};
            total_valid_q <= 1'b0;
            eoi_flag_q    <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_col_q     <= cur_col_d;
            op_col_q      <= op_col_d;
            row_q         <= row_d;
            mult_q        <= mult_d;
            acc_q         <= acc_d;
            total_q       <= total_d;
            total_data_q  <= total_data_d;
            total_valid_q <= total_valid_d;
            eoi_flag_q    <= eoi_flag_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    assign bus.total_valid = total_valid_q;
    assign bus.total_data  = total_data_q;
    assign bus.busy        = busy_q;
    assign bus.error       = error_q;

`ifdef COL_RESULT_OUT_EN
    logic    col_result_valid_q, col_result_valid_d;
    result_t col_result_data_q, col_result_data_d;

    // Mirror each column's reduced value as it is folded into the total.
    always_comb begin
        col_result_valid_d = (state_q == EMIT);
        if (state_q == EMIT) begin
            col_result_data_d = acc_q;
        end else begin
            col_result_data_d = col_result_data_q;
        end
    end

    // Per-column result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_result_valid_q <= 1'b0;
            col_result_data_q  <= {RESULT_WIDTH{1'b0}};
        end else begin
            col_result_valid_q <= col_result_valid_d;
            col_result_data_q  <= col_result_data_d;
        end
    end

    assign bus.col_result_valid = col_result_valid_q;
    assign bus.col_result_data  = col_result_data_q;
`else
    assign bus.col_result_valid = 1'b0;
    assign bus.col_result_data  = {RESULT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_column_problem_sequencer.sv
// Scoreboard bench for column_problem_sequencer: directed worksheets, queued expectations, negedge monitor.
module tb_column_problem_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    column_problem_sequencer_if bus();

    column_problem_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total    = 0;
    int bad      = 0;
    int n_totals = 0;
    logic [63:0] exp_total_q[$];
    logic [63:0] exp_col_q[$];

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic write_arg(input int row, input int col, input logic [15:0] data);
        bus.arg_valid = 1'b1;
        bus.arg_row   = row[1:0];
        bus.arg_col   = col[9:0];
        bus.arg_data  = data;
        cyc(1);
        bus.arg_valid = 1'b0;
    endtask

    task automatic write_col(input int col, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        write_arg(0, col, a);
        write_arg(1, col, b);
        write_arg(2, col, c);
    endtask

    task automatic push_op(input logic mult);
        bus.operand_valid    = 1'b1;
        bus.operand_mult_add = mult;
        cyc(1);
        bus.operand_valid    = 1'b0;
    endtask

    task automatic send_eoi();
        bus.end_of_input = 1'b1;
        cyc(1);
        bus.end_of_input = 1'b0;
    endtask

    task automatic expect_col(input logic [63:0] v);
`ifdef COL_RESULT_OUT_EN
        exp_col_q.push_back(v);
`else
        if (v == 64'd0) begin
            exp_col_q.delete();
        end
`endif
    endtask

    task automatic wait_total(input string name, input int budget);
        int start;
        int k;
        start = n_totals;
        k = 0;
        while (n_totals == start && k < budget) begin
            cyc(1);
            k++;
        end
        total++;
        if (n_totals == start) begin
            bad++;
            $display("FAIL %s: got no total_valid within %0d cycles, required one pulse", name, budget);
        end
    endtask

    // Monitor: every presented result is matched against the head of its expectation queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.total_valid === 1'b1) begin
            n_totals++;
            total++;
            if (exp_total_q.size() == 0) begin
                bad++;
                $display("FAIL total_unexpected: got pulse with %0d, required no pulse", bus.total_data);
            end else begin
                e = exp_total_q.pop_front();
                if (bus.total_data !== e) begin
                    bad++;
                    $display("FAIL total_data: got %0d, required %0d", bus.total_data, e);
                end
            end
        end
`ifdef COL_RESULT_OUT_EN
        if (bus.col_result_valid === 1'b1) begin
            total++;
            if (exp_col_q.size() == 0) begin
                bad++;
                $display("FAIL col_unexpected: got pulse with %0d, required no pulse", bus.col_result_data);
            end else begin
                e = exp_col_q.pop_front();
                if (bus.col_result_data !== e) begin
                    bad++;
                    $display("FAIL col_result: got %0d, required %0d", bus.col_result_data, e);
                end
            end
        end
`else
        if (bus.col_result_valid !== 1'b0 || bus.col_result_data !== 64'd0) begin
            total++;
            bad++;
            $display("FAIL col_tied: got valid=%0b data=%0d, required 0", bus.col_result_valid, bus.col_result_data);
        end
`endif
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_low;
        rst                  = 1'b1;
        bus.arg_valid        = 1'b0;
        bus.arg_row          = 2'd0;
        bus.arg_col          = 10'd0;
        bus.arg_data         = 16'd0;
        bus.operand_valid    = 1'b0;
        bus.operand_mult_add = 1'b0;
        bus.end_of_input     = 1'b0;
        do_reset();

        check("rst_total_valid", {63'd0, bus.total_valid}, 64'd0);
        check("rst_total_data", bus.total_data, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_error", {63'd0, bus.error}, 64'd0);
        check("rst_col_valid", {63'd0, bus.col_result_valid}, 64'd0);

        // Day-6 sample; end_of_input follows the operators while three are still queued.
        write_col(0, 16'd123, 16'd45, 16'd6);
        write_col(1, 16'd328, 16'd64, 16'd98);
        write_col(2, 16'd51, 16'd387, 16'd215);
        write_col(3, 16'd64, 16'd23, 16'd314);
        write_arg(3, 0, 16'hDEAD);
        expect_col(64'd33210);
        expect_col(64'd490);
        expect_col(64'd4243455);
        expect_col(64'd401);
        exp_total_q.push_back(64'd4277556);
        push_op(1'b1);
        push_op(1'b0);
        push_op(1'b1);
        push_op(1'b0);
        send_eoi();
        check("sample_busy_running", {63'd0, bus.busy}, 64'd1);
        wait_total("sample_total", 200);
        check("sample_error", {63'd0, bus.error}, 64'd0);
        check("sample_busy_idle", {63'd0, bus.busy}, 64'd0);
        cyc(10);
        check("sample_total_held", bus.total_data, 64'd4277556);
        check("sample_single_pulse", n_totals, 64'd1);

        // Back-to-back operator bursts, kept within the queue's drain rate.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            write_col(c, 16'd1, 16'd1, 16'd1);
            expect_col(64'd3);
        end
        exp_total_q.push_back(64'd36);
        busy_low = 0;
        bus.operand_mult_add = 1'b0;
        bus.operand_valid    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.busy !== 1'b1) busy_low++;
        end
        bus.operand_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (bus.busy !== 1'b1) busy_low++;
        end
        bus.operand_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            if (bus.busy !== 1'b1) busy_low++;
        end
        bus.operand_valid = 1'b0;
        send_eoi();
        if (bus.busy !== 1'b1) busy_low++;
        check("burst_busy_low_cycles", busy_low, 64'd0);
        wait_total("burst_total", 300);
        check("burst_error", {63'd0, bus.error}, 64'd0);
        check("burst_busy_drained", {63'd0, bus.busy}, 64'd0);

        // Eleven back-to-back operators overflow the queue: one column dropped.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            write_col(c, 16'd1, 16'd1, 16'd1);
        end
        for (int c = 0; c < 10; c++) expect_col(64'd3);
        exp_total_q.push_back(64'd30);
        bus.operand_mult_add = 1'b0;
        bus.operand_valid    = 1'b1;
        cyc(11);
        bus.operand_valid    = 1'b0;
        send_eoi();
        wait_total("ovf_total", 300);
        check("ovf_error", {63'd0, bus.error}, 64'd1);
        cyc(20);
        check("ovf_error_sticky", {63'd0, bus.error}, 64'd1);
        do_reset();
        check("ovf_error_cleared", {63'd0, bus.error}, 64'd0);

        // Full-scale multiply exercises the 64-bit accumulator.
        write_col(0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        expect_col(64'd281462092005375);
        exp_total_q.push_back(64'd281462092005375);
        push_op(1'b1);
        send_eoi();
        wait_total("mul_total", 100);

        // Reset during the second sample column's reduction abandons all work.
        do_reset();
        write_col(0, 16'd123, 16'd45, 16'd6);
        write_col(1, 16'd328, 16'd64, 16'd98);
        write_col(2, 16'd51, 16'd387, 16'd215);
        write_col(3, 16'd64, 16'd23, 16'd314);
        expect_col(64'd33210);
        push_op(1'b1);
        push_op(1'b0);
        push_op(1'b1);
        push_op(1'b0);
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_total_data", bus.total_data, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        write_col(0, 16'd2, 16'd3, 16'd4);
        expect_col(64'd9);
        exp_total_q.push_back(64'd9);
        push_op(1'b0);
        send_eoi();
        wait_total("midrst_total", 100);
        cyc(10);

        check("left_total_expect", exp_total_q.size(), 64'd0);
        check("left_col_expect", exp_col_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/column_problem_sequencer.md
Name: column_problem_sequencer

Overview:
- Consumes the decoded argument and operator streams of the day-6 worksheet parser.
- Stores the numeric arguments per column (one problem per column).
- Once a column's operator is known, schedules a multiply-or-add reduction over that column's rows on a single shared arithmetic stage.
- Accumulates all column results into a grand total, presented once end of input is signalled and all work has drained.

Parameters:
- ARG_ROWS, 3, number of argument rows per column; the operator row index equals ARG_ROWS.
- ARG_ROW_WIDTH, 2, width of the row index.
- ARG_COL_WIDTH, 10, width of the column index; column storage depth is 2**ARG_COL_WIDTH.
- ARG_DATA_WIDTH, 16, width of one argument.
- RESULT_WIDTH, 64, width of the column result and of the grand total.
- OP_FIFO_DEPTH, 8, number of pending operators buffered (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arg_valid  in  1  argument strobe.
- arg_row  in  ARG_ROW_WIDTH  argument row.
- arg_col  in  ARG_COL_WIDTH  argument column.
- arg_data  in  ARG_DATA_WIDTH  argument value.
- operand_valid  in  1  operator strobe.
- operand_mult_add  in  1  operator type: 1 = multiply, 0 = add.
- end_of_input  in  1  single-cycle pulse: no further strobes follow.
- total_valid  out  1  single-cycle pulse carrying the grand total.
- total_data  out  RESULT_WIDTH  grand total, held after the pulse.
- col_result_valid  out  1  per-column result strobe (optional feature).
- col_result_data  out  RESULT_WIDTH  per-column result (optional feature).
- busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- error  out  1  sticky error: FIFO overflow or column-index overflow.

Behaviour:
- Reset: all outputs 0; FIFO empty; op_col = 0; total = 0; FSM IDLE; end-of-input flag cleared. Argument RAM contents are not reset.
- Argument write: on arg_valid, mem[arg_row][arg_col] <= arg_data. Writes with arg_row >= ARG_ROWS are ignored.
- Operator capture:
  - operand_valid pushes {op_col, operand_mult_add} into op_fifo, then op_col increments.
  - The column index is generated locally and is never taken from an input.
  - Push when full: the entry is dropped and error is set.
  - op_col wrap from all-ones to 0: error is set.
- Ordering guarantee from the parser: every argument of column c is written before the operator of column c arrives.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop and latch col/op, issue a read of row 0, go to FIRST.
  - FIRST: acc <= zero-extended read data; issue a read of row 1; r = 1; go to REDUCE.
  - REDUCE: each cycle acc <= op ? acc*rd : acc+rd. If r == ARG_ROWS-1 go to EMIT, else r++ and issue the next read.
  - EMIT: total <= total + acc; go to IDLE.
- Memory reads are registered, with 1-cycle latency.
- Arithmetic is modulo 2**RESULT_WIDTH; there is no overflow detection.
- Column latency, from pop to total update: ARG_ROWS+2 cycles (5 at default).
- Pop and push in the same cycle are legal, including when the FIFO is full (no overflow in that case).
- Completion:
  - end_of_input sets a flag.
  - When the flag is set, the FSM is IDLE and the FIFO is empty, total_valid pulses for one cycle with total_data = total, and the flag clears.
  - If end_of_input arrives when already idle and drained, total_valid pulses in the next cycle.
- rst mid-column abandons the column: total is cleared, the FIFO is flushed, and nothing is emitted.

Optional Feature:
- Macro COL_RESULT_OUT_EN.
- Defined: in EMIT, col_result_valid pulses for one cycle with col_result_data = acc.
- Undefined: both ports are tied to 0 and no extra registers are built.
- Total behaviour is identical either way.

Decomposition:
- Package aoc25_6_pkg holds:
  - arg_row_t, arg_col_t, arg_data_t and result_t typedefs;
  - the op_entry_t struct {col, mult_add};
  - the seq_state_t enum {IDLE, FIRST, REDUCE, EMIT};
  - OPERAND_ROW.
- One sub-module, op_fifo: synchronous FIFO with push/pop/full/empty and an overflow flag, reset by rst.

Test Plan:
- Day-6 sample (columns 123/45/6 *, 328/64/98 +, 51/387/215 *, 64/23/314 +), then end_of_input -> total_data = 4277556, one total_valid pulse; with COL_RESULT_OUT_EN, col results 33210, 490, 4243455, 401 in order.
- Back-to-back operator strobes every cycle for 12 columns of (1, 1, 1, +) with depth 8 -> no error; total = 36, and busy stays high until drained.
- 9 operator pushes while the FSM is held busy on a long column, overflowing depth 8 -> error = 1 (sticky) and one column missing from the total.
- Column (65535, 65535, 65535, *) -> acc = 281462092005375; the total is exact in 64 bits.
- rst asserted during REDUCE of column 2 of the sample, then a single column 2/3/4 + is sent with end_of_input -> total = 9, no stale result.
- end_of_input asserted while 3 operators are still queued -> total_valid only after the last EMIT, exactly once.
